// File: rtl/qk_score_unit.sv
// Scores a latched query against cached keys 0..seq_len-1, one signed dot product per position, streamed out valid/ready.
// Optional build macro QK_VALID_MASK_EN forces unwritten entries to the most-negative score; 4 cycles/score, stalls in OUT.
module qk_score_unit #(
    parameter int MAX_SEQ_LEN = 8,
    parameter int HEAD_DIM    = 12,
    parameter int DW          = 4,
    parameter int AW          = $clog2(MAX_SEQ_LEN),
    parameter int SW          = 2*DW + $clog2(HEAD_DIM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [HEAD_DIM*DW-1:0] q_vec,
    input  logic [AW:0]            seq_len,
    output logic [AW-1:0]          cache_read_addr,
    input  logic [HEAD_DIM*DW-1:0] cache_data,
    input  logic                   cache_valid,
    output logic [SW-1:0]          score_out,
    output logic [AW-1:0]          score_idx,
    output logic                   score_last,
    output logic                   score_valid,
    input  logic                   score_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err_invalid
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CALC, S_OUT, S_FIN} state_t;

    localparam logic [SW-1:0] MOST_NEG = {1'b1, {(SW-1){1'b0}}};

    state_t                  state_q;
    logic [HEAD_DIM*DW-1:0]  q_q;
    logic [HEAD_DIM*DW-1:0]  k_q;
    logic                    kvld_q;
    logic [AW:0]             len_q;
    logic [AW-1:0]           idx_q;
    logic [AW:0]             len_d;
    logic signed [SW-1:0]    dot_d;
    logic signed [SW-1:0]    qe;
    logic signed [SW-1:0]    ke;
    logic                    is_last;

    assign len_d   = (seq_len > (AW+1)'(MAX_SEQ_LEN)) ? (AW+1)'(MAX_SEQ_LEN) : seq_len;
    assign is_last = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

    // Element 0 lives in the MSBs; each product is widened before summing so the sum cannot wrap.
    always_comb begin
        dot_d = '0;
        qe    = '0;
        ke    = '0;
        for (int h = 0; h < HEAD_DIM; h++) begin
            qe    = SW'($signed(q_q[(HEAD_DIM-h)*DW-1 -: DW]));
            ke    = SW'($signed(k_q[(HEAD_DIM-h)*DW-1 -: DW]));
            dot_d = dot_d + qe * ke;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            q_q             <= '0;
            k_q             <= '0;
            kvld_q          <= 1'b0;
            len_q           <= '0;
            idx_q           <= '0;
            cache_read_addr <= '0;
            score_out       <= '0;
            score_idx       <= '0;
            score_last      <= 1'b0;
            score_valid     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_invalid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_q         <= q_vec;
                        len_q       <= len_d;
                        err_invalid <= 1'b0;
                        busy        <= 1'b1;
                        idx_q       <= '0;
                        if (len_d == '0) begin
                            state_q <= S_FIN;
                        end else begin
                            cache_read_addr <= '0;
                            state_q         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cache_read_addr <= idx_q;
                    state_q         <= S_WAIT;
                end
                S_WAIT: begin
                    k_q     <= cache_data;
                    kvld_q  <= cache_valid;
                    state_q <= S_CALC;
                end
                S_CALC: begin
`ifdef QK_VALID_MASK_EN
                    score_out <= kvld_q ? dot_d : MOST_NEG;
`else
                    score_out <= dot_d;
`endif
                    if (!kvld_q) begin
                        err_invalid <= 1'b1;
                    end
                    score_idx   <= idx_q;
                    score_last  <= is_last;
                    score_valid <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (score_ready) begin
                        score_valid <= 1'b0;
                        score_last  <= 1'b0;
                        if (is_last) begin
                            state_q <= S_FIN;
                        end else begin
                            idx_q           <= idx_q + AW'(1);
                            cache_read_addr <= idx_q + AW'(1);
                            state_q         <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
